// File: rtl/mem_stage_dmem_if.sv
// EX/MEM -> MEM/WB bus for the RV32I memory stage.
// The master drives the access request, and the slave returns the registered writeback slot.
interface mem_stage_dmem_if;
    // EX/MEM request
    logic        valid_in;
    logic        stall;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd_in;
    logic        reg_write_in;
    logic        mem_to_reg_in;

    // MEM/WB response
    logic        valid_out;
    logic [31:0] rdata_out;
    logic [31:0] alu_result_out;
    logic [4:0]  rd_out;
    logic        reg_write_out;
    logic        mem_to_reg_out;
    logic        fault_out;

    modport master (
        output valid_in, stall, mem_read, mem_write, funct3, addr, wdata,
               rd_in, reg_write_in, mem_to_reg_in,
        input  valid_out, rdata_out, alu_result_out, rd_out, reg_write_out,
               mem_to_reg_out, fault_out
    );

    modport slave (
        input  valid_in, stall, mem_read, mem_write, funct3, addr, wdata,
               rd_in, reg_write_in, mem_to_reg_in,
        output valid_out, rdata_out, alu_result_out, rd_out, reg_write_out,
               mem_to_reg_out, fault_out
    );
endinterface

// File: rtl/mem_stage_dmem.sv
// RV32I memory stage: byte-lane loads and stores on a word-organised data memory.
// The stage registers the load data and the writeback control into the MEM/WB boundary.
module mem_stage_dmem #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    mem_stage_dmem_if.slave   bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    logic [31:0]   mem [DEPTH_WORDS];

    logic [AW-1:0] word_idx;
    logic [1:0]    lane;
    logic          store_op;
    logic          load_op;
    logic          misaligned;
    logic          illegal;
    logic          fault;
    logic          access_ok;
    logic          do_write;
    logic [3:0]    byte_en;
    logic [31:0]   wdata_lanes;
    logic [31:0]   rword;
    logic [7:0]    rbyte;
    logic [15:0]   rhalf;
    logic [31:0]   load_ext;
    logic [31:0]   rdata_next;

    // Upper address bits are dropped, so the address space aliases modulo the memory size.
    assign word_idx = bus.addr[AW+1:2];
    assign lane     = bus.addr[1:0];

    // When both strobes are set, the store wins and the load is dropped.
    assign store_op = bus.mem_write;
    assign load_op  = bus.mem_read & ~bus.mem_write;

    // NOTE: every signal assigned in an always_comb gets a default value first.
    // Without a default, a case arm that skips a signal would infer a latch.
    always_comb begin
        misaligned = 1'b0;
        illegal    = 1'b0;
        if (store_op) begin
            case (bus.funct3)
                F3_B:    misaligned = 1'b0;
                F3_H:    misaligned = lane[0];
                F3_W:    misaligned = |lane;
                default: illegal    = 1'b1;
            endcase
        end else if (load_op) begin
            case (bus.funct3)
                F3_B, F3_BU: misaligned = 1'b0;
                F3_H, F3_HU: misaligned = lane[0];
                F3_W:        misaligned = |lane;
                default:     illegal    = 1'b1;
            endcase
        end
    end

    assign fault     = misaligned | illegal;
    assign access_ok = bus.valid_in & ~fault;
    assign do_write  = access_ok & store_op;

    // Store data is replicated across the lanes, and the byte enables pick the lanes to update.
    always_comb begin
        byte_en     = 4'b0000;
        wdata_lanes = bus.wdata;
        case (bus.funct3)
            F3_B: begin
                byte_en     = 4'b0001 << lane;
                wdata_lanes = {4{bus.wdata[7:0]}};
            end
            F3_H: begin
                byte_en     = lane[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{bus.wdata[15:0]}};
            end
            F3_W: byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    end

    // The array is read before the edge, so a load sees the contents from before this cycle's write.
    assign rword = mem[word_idx];

    always_comb begin
        case (lane)
            2'd0:    rbyte = rword[7:0];
            2'd1:    rbyte = rword[15:8];
            2'd2:    rbyte = rword[23:16];
            default: rbyte = rword[31:24];
        endcase
        rhalf = lane[1] ? rword[31:16] : rword[15:0];

        case (bus.funct3)
            F3_B:    load_ext = {{24{rbyte[7]}}, rbyte};
            F3_H:    load_ext = {{16{rhalf[15]}}, rhalf};
            F3_W:    load_ext = rword;
            F3_BU:   load_ext = {24'h0, rbyte};
            F3_HU:   load_ext = {16'h0, rhalf};
            default: load_ext = 32'h0;
        endcase
    end

    assign rdata_next = (access_ok & load_op) ? load_ext : 32'h0;

    // NOTE: sequential state uses non-blocking assignments only.
    // With blocking assignments, the result would depend on the order in which the always blocks run.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the whole array is cleared in the reset cycle.
            // Because of this, the storage is built from flops and cannot map to a RAM macro.
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
            bus.valid_out      <= 1'b0;
            bus.rdata_out      <= '0;
            bus.alu_result_out <= '0;
            bus.rd_out         <= '0;
            bus.reg_write_out  <= 1'b0;
            bus.mem_to_reg_out <= 1'b0;
            bus.fault_out      <= 1'b0;
        end else if (!bus.stall) begin
            if (do_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (byte_en[b]) begin
                        mem[word_idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
                    end
                end
            end
            bus.valid_out      <= bus.valid_in;
            bus.rdata_out      <= rdata_next;
            bus.alu_result_out <= bus.addr;
            bus.rd_out         <= bus.rd_in;
            bus.reg_write_out  <= bus.valid_in & bus.reg_write_in & ~fault;
            bus.mem_to_reg_out <= bus.mem_to_reg_in;
            bus.fault_out      <= bus.valid_in & fault;
        end
    end
endmodule

// File: tb/tb_mem_stage_dmem.sv
// Scoreboard bench for mem_stage_dmem.
// The driver pushes hand-computed responses, and a monitor on the falling edge pops and compares them.
module tb_mem_stage_dmem;
    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        rw;
        logic        m2r;
        logic        fault;
    } resp_t;

    logic clk;
    logic reset;
    mem_stage_dmem_if bus ();

    mem_stage_dmem #(.DEPTH_WORDS(256)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    resp_t exp_q[$];
    string tag_q[$];
    resp_t last_exp;
    int    n_checks = 0;
    int    n_pass   = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: one response per clock once the scoreboard holds entries.
    initial begin
        resp_t e;
        string t;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check({t, ".valid"}, 32'(bus.valid_out),      32'(e.valid));
                check({t, ".rdata"}, bus.rdata_out,           e.rdata);
                check({t, ".alu"},   bus.alu_result_out,      e.alu);
                check({t, ".rd"},    32'(bus.rd_out),         32'(e.rd));
                check({t, ".rw"},    32'(bus.reg_write_out),  32'(e.rw));
                check({t, ".m2r"},   32'(bus.mem_to_reg_out), 32'(e.m2r));
                check({t, ".fault"}, 32'(bus.fault_out),      32'(e.fault));
            end
        end
    end

    task automatic drive(logic vld, logic stl, logic rd, logic wr, logic [2:0] f3,
                         logic [31:0] a, logic [31:0] wd, logic [4:0] rdi, logic rw, logic m2r);
        bus.valid_in      = vld;
        bus.stall         = stl;
        bus.mem_read      = rd;
        bus.mem_write     = wr;
        bus.funct3        = f3;
        bus.addr          = a;
        bus.wdata         = wd;
        bus.rd_in         = rdi;
        bus.reg_write_in  = rw;
        bus.mem_to_reg_in = m2r;
    endtask

    task automatic do_reset(string tag);
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h44, 32'h5555_5555, 5'd9, 1'b1, 1'b1);
        @(posedge clk);
        last_exp = '0;
        exp_q.push_back(last_exp);
        tag_q.push_back(tag);
        #1 reset = 1'b0;
    endtask

    task automatic issue(string tag, logic vld, logic stl, logic rd, logic wr, logic [2:0] f3,
                         logic [31:0] a, logic [31:0] wd, logic [4:0] rdi, logic rw, logic m2r,
                         logic [31:0] exp_rdata, logic exp_fault);
        resp_t e;
        drive(vld, stl, rd, wr, f3, a, wd, rdi, rw, m2r);
        @(posedge clk);
        if (stl) begin
            e = last_exp;
        end else begin
            e.valid = vld;
            e.rdata = vld ? exp_rdata : 32'h0;
            e.alu   = a;
            e.rd    = rdi;
            e.rw    = vld & rw & ~exp_fault;
            e.m2r   = m2r;
            e.fault = vld & exp_fault;
        end
        last_exp = e;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #1;
    endtask

    task automatic store(string tag, logic [2:0] f3, logic [31:0] a, logic [31:0] wd, logic flt);
        issue(tag, 1'b1, 1'b0, 1'b0, 1'b1, f3, a, wd, 5'd0, 1'b0, 1'b0, 32'h0, flt);
    endtask

    task automatic load(string tag, logic [2:0] f3, logic [31:0] a, logic [31:0] exp, logic flt);
        issue(tag, 1'b1, 1'b0, 1'b1, 1'b0, f3, a, 32'h0, 5'd10, 1'b1, 1'b1, exp, flt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        do_reset("reset0");

        // Memory is cleared by a reset that also carries a stalled store.
        store("sw_pre_reset", 3'b010, 32'h40, 32'hDEAD_BEEF, 1'b0);
        do_reset("reset_stall_store");
        load("lw_after_reset_40", 3'b010, 32'h40, 32'h0, 1'b0);
        load("lw_after_reset_44", 3'b010, 32'h44, 32'h0, 1'b0);

        // Load width and sign handling.
        store("sw_10", 3'b010, 32'h10, 32'h8081_82F3, 1'b0);
        load("lb_10",  3'b000, 32'h10, 32'hFFFF_FFF3, 1'b0);
        load("lbu_10", 3'b100, 32'h10, 32'h0000_00F3, 1'b0);
        load("lh_12",  3'b001, 32'h12, 32'hFFFF_8081, 1'b0);
        load("lhu_12", 3'b101, 32'h12, 32'h0000_8081, 1'b0);
        load("lw_10",  3'b010, 32'h10, 32'h8081_82F3, 1'b0);
        load("lbu_13", 3'b100, 32'h13, 32'h0000_0080, 1'b0);

        // Partial stores keep the bytes they do not write.
        store("sw_20", 3'b010, 32'h20, 32'h1122_3344, 1'b0);
        store("sb_21", 3'b000, 32'h21, 32'h0000_00AA, 1'b0);
        load("lw_20_sb", 3'b010, 32'h20, 32'h1122_AA44, 1'b0);
        store("sh_22", 3'b001, 32'h22, 32'h0000_BEEF, 1'b0);
        load("lw_20_sh", 3'b010, 32'h20, 32'hBEEF_AA44, 1'b0);

        // Misaligned and illegal accesses.
        store("sw_13_mis", 3'b010, 32'h13, 32'hFFFF_FFFF, 1'b1);
        load("lh_05_mis",  3'b001, 32'h05, 32'h0, 1'b1);
        load("ld_f3_011",  3'b011, 32'h10, 32'h0, 1'b1);
        load("lw_12_mis",  3'b010, 32'h12, 32'h0, 1'b1);
        store("st_f3_011", 3'b011, 32'h20, 32'hFFFF_FFFF, 1'b1);
        load("lw_10_intact", 3'b010, 32'h10, 32'h8081_82F3, 1'b0);
        load("lw_20_intact", 3'b010, 32'h20, 32'hBEEF_AA44, 1'b0);

        // When both strobes are set, the store takes effect and the load is dropped.
        issue("rd_wr_both", 1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h50, 32'h0BAD_F00D,
              5'd4, 1'b1, 1'b1, 32'h0, 1'b0);
        load("lw_50", 3'b010, 32'h50, 32'h0BAD_F00D, 1'b0);

        // A non-memory op passes the ALU result through.
        issue("alu_pass", 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0,
              5'd3, 1'b1, 1'b0, 32'h0, 1'b0);

        // Address aliasing modulo 1 KiB.
        store("sw_400", 3'b010, 32'h400, 32'hCAFE_BABE, 1'b0);
        load("lw_000_alias", 3'b010, 32'h000, 32'hCAFE_BABE, 1'b0);

        // A stall freezes the outputs and blocks the pending store.
        store("sw_30", 3'b010, 32'h30, 32'h0F0F_0F0F, 1'b0);
        load("lw_30", 3'b010, 32'h30, 32'h0F0F_0F0F, 1'b0);
        for (int i = 0; i < 3; i++) begin
            issue("stall_sw_30", 1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h30, 32'h1234_5678,
                  5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
        end
        load("lw_30_after_stall", 3'b010, 32'h30, 32'h0F0F_0F0F, 1'b0);

        // An invalid slot performs no write and reports no fault.
        issue("invalid_sw", 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 32'h30, 32'h9999_9999,
              5'd7, 1'b1, 1'b1, 32'h0, 1'b0);
        issue("invalid_mis", 1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 32'h31, 32'h0,
              5'd8, 1'b1, 1'b0, 32'h0, 1'b0);
        load("lw_30_after_invalid", 3'b010, 32'h30, 32'h0F0F_0F0F, 1'b0);

        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
